m3_commutation_seq: RTL and testbench

- Parametrised successor to the fixed 12-step sequencer in the 3-phase motor controller.
- Holds the speed (step period) and power (PWM duty) set-points and adjusts them from INC/DEC pulses.
- Runs a start/stop state machine and a step counter with programmable step count and latched rotation direction.
- Drives the step index, a step strobe and a PWM enable into the downstream phase-gate decoder.

---
 rtl/m3_commutation_seq.sv | 199 +++++++++++++++++++
 tb/tb_m3_commutation_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/m3_commutation_seq.sv
// Parametrised commutation sequencer for a 3-phase motor: speed/power set-points,
// IDLE/RUN control, programmable step count with latched direction, and registered PWM enable.
module m3_commutation_seq #(
    parameter int STEPS    = 12,
    parameter int PER_W    = 16,
    parameter int PER_INIT = 1000,
    parameter int PER_MIN  = 100,
    parameter int PER_MAX  = 60000,
    parameter int PER_STEP = 50,
    parameter int PWR_W    = 8,
    parameter int PWR_MAX  = 255,
    parameter int PWR_INIT = 0,
    parameter int PWR_STEP = 8
) (
    input  logic                         clkI,
    input  logic                         nRstI,
    input  logic                         m3startI,
    input  logic                         m3forceStopI,
    input  logic                         m3invRotateI,
    input  logic                         m3freqINCi,
    input  logic                         m3freqDECi,
    input  logic                         m3powerINCi,
    input  logic                         m3powerDECi,
    output logic [$clog2(STEPS+1)-1:0]   m3stepO,
    output logic                         m3stepStbO,
    output logic                         m3runO,
    output logic                         m3dirO,
    output logic                         m3pwmO,
    output logic [PER_W-1:0]             m3periodO,
    output logic [PWR_W-1:0]             m3powerO
);

    localparam int SW = $clog2(STEPS + 1);

    localparam logic [PER_W:0]   PER_MIN_W  = (PER_W+1)'(PER_MIN);
    localparam logic [PER_W:0]   PER_MAX_W  = (PER_W+1)'(PER_MAX);
    localparam logic [PER_W:0]   PER_STEP_W = (PER_W+1)'(PER_STEP);
    localparam logic [PWR_W:0]   PWR_MAX_W  = (PWR_W+1)'(PWR_MAX);
    localparam logic [PWR_W:0]   PWR_STEP_W = (PWR_W+1)'(PWR_STEP);
    localparam logic [PWR_W-1:0] CNT_LAST   = PWR_W'(PWR_MAX - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     step_q, step_d;
    logic              stb_q, stb_d;
    logic              dir_q, dir_d;
    logic              pwm_q, pwm_d;
    logic [PER_W-1:0]  tick_q, tick_d;
    logic [PWR_W-1:0]  cnt_q, cnt_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic [PWR_W-1:0]  power_q, power_d;

    logic              start_edge;
    logic              stop_edge;
    logic              step_due;
    logic [SW-1:0]     step_adv;
    logic [PER_W:0]    per_up_w;
    logic [PWR_W:0]    pwr_up_w;

    // ---------------- state register ----------------
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (m3startI && !m3forceStopI) state_d = S_RUN;
            S_RUN:   if (m3forceStopI) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign start_edge = (state_q == S_IDLE) && (state_d == S_RUN);
    assign stop_edge  = (state_q == S_RUN) && (state_d == S_IDLE);

    // Compare one bit wider so tick >= period-1 never underflows.
    assign step_due = ({1'b0, tick_q} + (PER_W+1)'(1)) >= {1'b0, period_q};

    always_comb begin
        if (!dir_q) begin
            step_adv = (step_q >= SW'(STEPS)) ? SW'(1) : step_q + SW'(1);
        end else begin
            step_adv = (step_q <= SW'(1)) ? SW'(STEPS) : step_q - SW'(1);
        end
    end

    // ---------------- output / datapath next values ----------------
    always_comb begin
        step_d = step_q;
        stb_d  = 1'b0;
        dir_d  = dir_q;
        tick_d = tick_q;
        if (start_edge) begin
            step_d = SW'(1);
            tick_d = '0;
            dir_d  = m3invRotateI;
            stb_d  = 1'b1;
        end else if (stop_edge) begin
            step_d = '0;
            tick_d = '0;
        end else if (state_q == S_RUN) begin
            if (step_due) begin
                tick_d = '0;
                step_d = step_adv;
                stb_d  = 1'b1;
            end else begin
                tick_d = tick_q + PER_W'(1);
            end
        end
    end

    // PWM carrier restarts on entry to RUN so the first step sees a full duty window.
    always_comb begin
        if (start_edge || (cnt_q >= CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PWR_W'(1);
        end
        pwm_d = (state_q == S_RUN) && (state_d == S_RUN) && (cnt_q < power_q);
    end

    always_comb begin
        period_d = period_q;
        per_up_w = {1'b0, period_q} + PER_STEP_W;
        if (m3freqINCi && !m3freqDECi) begin
            if ({1'b0, period_q} < (PER_MIN_W + PER_STEP_W)) begin
                period_d = PER_MIN_W[PER_W-1:0];
            end else begin
                period_d = period_q - PER_STEP_W[PER_W-1:0];
            end
        end else if (m3freqDECi && !m3freqINCi) begin
            if (per_up_w > PER_MAX_W) begin
                period_d = PER_MAX_W[PER_W-1:0];
            end else begin
                period_d = per_up_w[PER_W-1:0];
            end
        end
    end

    always_comb begin
        power_d  = power_q;
        pwr_up_w = {1'b0, power_q} + PWR_STEP_W;
        if (m3powerINCi && !m3powerDECi) begin
            if (pwr_up_w > PWR_MAX_W) begin
                power_d = PWR_MAX_W[PWR_W-1:0];
            end else begin
                power_d = pwr_up_w[PWR_W-1:0];
            end
        end else if (m3powerDECi && !m3powerINCi) begin
            if ({1'b0, power_q} < PWR_STEP_W) begin
                power_d = '0;
            end else begin
                power_d = power_q - PWR_STEP_W[PWR_W-1:0];
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            step_q   <= '0;
            stb_q    <= 1'b0;
            dir_q    <= 1'b0;
            pwm_q    <= 1'b0;
            tick_q   <= '0;
            cnt_q    <= '0;
            period_q <= PER_W'(PER_INIT);
            power_q  <= PWR_W'(PWR_INIT);
        end else begin
            step_q   <= step_d;
            stb_q    <= stb_d;
            dir_q    <= dir_d;
            pwm_q    <= pwm_d;
            tick_q   <= tick_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            power_q  <= power_d;
        end
    end

    assign m3stepO    = step_q;
    assign m3stepStbO = stb_q;
    assign m3runO     = (state_q == S_RUN);
    assign m3dirO     = dir_q;
    assign m3pwmO     = pwm_q;
    assign m3periodO  = period_q;
    assign m3powerO   = power_q;

endmodule

// File: tb/tb_m3_commutation_seq.sv
// Directed bench for m3_commutation_seq: instance A (12 steps, period 4) and
// instance B (6 steps, period 3) share all inputs.
module tb_m3_commutation_seq;

    logic clk;
    logic rst_n;
    logic start, force_stop, inv, finc, fdec, pinc, pdec;

    logic [3:0]  a_step;
    logic        a_stb, a_run, a_dir, a_pwm;
    logic [15:0] a_period;
    logic [7:0]  a_power;

    logic [2:0]  b_step;
    logic        b_stb, b_run, b_dir, b_pwm;
    logic [15:0] b_period;
    logic [7:0]  b_power;

    int checks = 0;
    int errors = 0;

    m3_commutation_seq #(
        .STEPS(12), .PER_W(16), .PER_INIT(4), .PER_MIN(2), .PER_MAX(14), .PER_STEP(2),
        .PWR_W(8), .PWR_MAX(255), .PWR_INIT(0), .PWR_STEP(8)
    ) dut_a (
        .clkI(clk), .nRstI(rst_n), .m3startI(start), .m3forceStopI(force_stop),
        .m3invRotateI(inv), .m3freqINCi(finc), .m3freqDECi(fdec),
        .m3powerINCi(pinc), .m3powerDECi(pdec),
        .m3stepO(a_step), .m3stepStbO(a_stb), .m3runO(a_run), .m3dirO(a_dir),
        .m3pwmO(a_pwm), .m3periodO(a_period), .m3powerO(a_power)
    );

    m3_commutation_seq #(
        .STEPS(6), .PER_W(16), .PER_INIT(3), .PER_MIN(2), .PER_MAX(100), .PER_STEP(1),
        .PWR_W(8), .PWR_MAX(255), .PWR_INIT(0), .PWR_STEP(8)
    ) dut_b (
        .clkI(clk), .nRstI(rst_n), .m3startI(start), .m3forceStopI(force_stop),
        .m3invRotateI(inv), .m3freqINCi(finc), .m3freqDECi(fdec),
        .m3powerINCi(pinc), .m3powerDECi(pdec),
        .m3stepO(b_step), .m3stepStbO(b_stb), .m3runO(b_run), .m3dirO(b_dir),
        .m3pwmO(b_pwm), .m3periodO(b_period), .m3powerO(b_power)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 0; force_stop = 0; inv = 0;
        finc = 0; fdec = 0; pinc = 0; pdec = 0;
        rst_n = 0;
        repeat (2) next_cycle();
        rst_n = 1;
    endtask

    task automatic pulse_start(input logic dir);
        inv = dir;
        start = 1;
        next_cycle();
        start = 0;
    endtask

    task automatic pulse_stop();
        force_stop = 1;
        next_cycle();
        force_stop = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (a_step !== 4'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", a_step); end
        checks++; if (a_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", a_stb); end
        checks++; if (a_run !== 1'b0) begin errors++; $display("FAIL reset_run: got %b expected 0", a_run); end
        checks++; if (a_dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %b expected 0", a_dir); end
        checks++; if (a_pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b expected 0", a_pwm); end
        checks++; if (a_period !== 16'd4) begin errors++; $display("FAIL reset_period_a: got %0d expected 4", a_period); end
        checks++; if (b_period !== 16'd3) begin errors++; $display("FAIL reset_period_b: got %0d expected 3", b_period); end
        checks++; if (a_power !== 8'd0) begin errors++; $display("FAIL reset_power: got %0d expected 0", a_power); end
        next_cycle();
        checks++; if (a_run !== 1'b0) begin errors++; $display("FAIL idle_hold_run: got %b expected 0", a_run); end
    endtask

    task automatic test_forward();
        int exp_step;
        logic exp_stb;
        pulse_start(1'b0);
        checks++; if (a_dir !== 1'b0) begin errors++; $display("FAIL fwd_dir: got %b expected 0", a_dir); end
        for (int k = 1; k <= 52; k++) begin
            exp_step = ((k - 1) / 4) % 12 + 1;
            exp_stb  = ((k - 1) % 4 == 0);
            checks++; if (a_step !== 4'(exp_step)) begin errors++; $display("FAIL fwd_step k=%0d: got %0d expected %0d", k, a_step, exp_step); end
            checks++; if (a_stb !== exp_stb) begin errors++; $display("FAIL fwd_stb k=%0d: got %b expected %b", k, a_stb, exp_stb); end
            checks++; if (a_run !== 1'b1) begin errors++; $display("FAIL fwd_run k=%0d: got %b expected 1", k, a_run); end
            next_cycle();
        end
    endtask

    task automatic test_force_stop();
        int exp_step;
        logic exp_stb;
        next_cycle();
        pulse_stop();
        checks++; if (a_step !== 4'd0) begin errors++; $display("FAIL stop_step: got %0d expected 0", a_step); end
        checks++; if (a_run !== 1'b0) begin errors++; $display("FAIL stop_run: got %b expected 0", a_run); end
        checks++; if (a_pwm !== 1'b0) begin errors++; $display("FAIL stop_pwm: got %b expected 0", a_pwm); end
        checks++; if (a_stb !== 1'b0) begin errors++; $display("FAIL stop_stb: got %b expected 0", a_stb); end
        checks++; if (a_period !== 16'd4) begin errors++; $display("FAIL stop_period: got %0d expected 4", a_period); end
        // start and forceStop together from IDLE must stay idle
        start = 1; force_stop = 1;
        next_cycle();
        start = 0; force_stop = 0;
        checks++; if (a_run !== 1'b0) begin errors++; $display("FAIL start_and_stop_run: got %b expected 0", a_run); end
        checks++; if (a_step !== 4'd0) begin errors++; $display("FAIL start_and_stop_step: got %0d expected 0", a_step); end
        pulse_start(1'b0);
        for (int k = 1; k <= 5; k++) begin
            exp_step = (k <= 4) ? 1 : 2;
            exp_stb  = (k == 1 || k == 5);
            checks++; if (a_step !== 4'(exp_step)) begin errors++; $display("FAIL restart_step k=%0d: got %0d expected %0d", k, a_step, exp_step); end
            checks++; if (a_stb !== exp_stb) begin errors++; $display("FAIL restart_stb k=%0d: got %b expected %b", k, a_stb, exp_stb); end
            next_cycle();
        end
        pulse_stop();
    endtask

    task automatic test_reverse();
        int idx;
        int exp_step;
        logic exp_stb;
        do_reset();
        pulse_start(1'b1);
        for (int k = 1; k <= 21; k++) begin
            idx      = (k - 1) / 3;
            exp_step = ((6 - (idx % 6)) % 6) + 1;
            exp_stb  = ((k - 1) % 3 == 0);
            checks++; if (b_step !== 3'(exp_step)) begin errors++; $display("FAIL rev_step k=%0d: got %0d expected %0d", k, b_step, exp_step); end
            checks++; if (b_stb !== exp_stb) begin errors++; $display("FAIL rev_stb k=%0d: got %b expected %b", k, b_stb, exp_stb); end
            checks++; if (b_dir !== 1'b1) begin errors++; $display("FAIL rev_dir k=%0d: got %b expected 1", k, b_dir); end
            inv = k[0];
            next_cycle();
        end
        pulse_stop();
        checks++; if (b_step !== 3'd0) begin errors++; $display("FAIL rev_stop_step: got %0d expected 0", b_step); end
    endtask

    task automatic test_period();
        logic [15:0] exp_inc [3];
        logic [15:0] exp_dec [7];
        exp_inc = '{16'd2, 16'd2, 16'd2};
        exp_dec = '{16'd4, 16'd6, 16'd8, 16'd10, 16'd12, 16'd14, 16'd14};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            finc = 1;
            next_cycle();
            finc = 0;
            checks++; if (a_period !== exp_inc[i]) begin errors++; $display("FAIL period_inc %0d: got %0d expected %0d", i, a_period, exp_inc[i]); end
        end
        finc = 1; fdec = 1;
        next_cycle();
        finc = 0; fdec = 0;
        checks++; if (a_period !== 16'd2) begin errors++; $display("FAIL period_inc_dec: got %0d expected 2", a_period); end
        for (int i = 0; i < 7; i++) begin
            fdec = 1;
            next_cycle();
            fdec = 0;
            checks++; if (a_period !== exp_dec[i]) begin errors++; $display("FAIL period_dec %0d: got %0d expected %0d", i, a_period, exp_dec[i]); end
        end
    endtask

    task automatic test_power();
        int exp_pwr;
        int high_cnt;
        pdec = 1;
        next_cycle();
        pdec = 0;
        checks++; if (a_power !== 8'd0) begin errors++; $display("FAIL power_dec_floor: got %0d expected 0", a_power); end
        for (int i = 1; i <= 32; i++) begin
            exp_pwr = (i * 8 > 255) ? 255 : i * 8;
            pinc = 1;
            next_cycle();
            pinc = 0;
            checks++; if (a_power !== 8'(exp_pwr)) begin errors++; $display("FAIL power_inc %0d: got %0d expected %0d", i, a_power, exp_pwr); end
        end
        pinc = 1; pdec = 1;
        next_cycle();
        pinc = 0; pdec = 0;
        checks++; if (a_power !== 8'd255) begin errors++; $display("FAIL power_inc_dec: got %0d expected 255", a_power); end
        checks++; if (a_pwm !== 1'b0) begin errors++; $display("FAIL pwm_idle: got %b expected 0", a_pwm); end
        pulse_start(1'b0);
        repeat (2) next_cycle();
        high_cnt = 0;
        for (int i = 0; i < 255; i++) begin
            high_cnt += int'(a_pwm);
            next_cycle();
        end
        checks++; if (high_cnt !== 255) begin errors++; $display("FAIL pwm_full: got %0d expected 255", high_cnt); end
        pulse_stop();
        checks++; if (a_power !== 8'd255) begin errors++; $display("FAIL stop_power_kept: got %0d expected 255", a_power); end
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pinc = 1;
            next_cycle();
            pinc = 0;
        end
        checks++; if (a_power !== 8'd64) begin errors++; $display("FAIL power_64: got %0d expected 64", a_power); end
        pulse_start(1'b0);
        repeat (2) next_cycle();
        high_cnt = 0;
        for (int i = 0; i < 255; i++) begin
            high_cnt += int'(a_pwm);
            next_cycle();
        end
        checks++; if (high_cnt !== 64) begin errors++; $display("FAIL pwm_64: got %0d expected 64", high_cnt); end
    endtask

    task automatic test_async_reset();
        pulse_stop();
        finc = 1;
        next_cycle();
        finc = 0;
        pulse_start(1'b1);
        repeat (3) next_cycle();
        checks++; if (a_run !== 1'b1) begin errors++; $display("FAIL pre_areset_run: got %b expected 1", a_run); end
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        checks++; if (a_step !== 4'd0) begin errors++; $display("FAIL areset_step: got %0d expected 0", a_step); end
        checks++; if (a_run !== 1'b0) begin errors++; $display("FAIL areset_run: got %b expected 0", a_run); end
        checks++; if (a_dir !== 1'b0) begin errors++; $display("FAIL areset_dir: got %b expected 0", a_dir); end
        checks++; if (a_pwm !== 1'b0) begin errors++; $display("FAIL areset_pwm: got %b expected 0", a_pwm); end
        checks++; if (a_stb !== 1'b0) begin errors++; $display("FAIL areset_stb: got %b expected 0", a_stb); end
        checks++; if (a_period !== 16'd4) begin errors++; $display("FAIL areset_period: got %0d expected 4", a_period); end
        checks++; if (a_power !== 8'd0) begin errors++; $display("FAIL areset_power: got %0d expected 0", a_power); end
        next_cycle();
        rst_n = 1;
        next_cycle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 0;
        start = 0; force_stop = 0; inv = 0;
        finc = 0; fdec = 0; pinc = 0; pdec = 0;
        test_reset();
        test_forward();
        test_force_stop();
        test_reverse();
        test_period();
        test_power();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
